// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain loader: streams bitstream words MSB-first onto ccff_head.
// Define CCFF_CHAIN_LOADER_READBACK_EN to add rb_ones, a popcount of bits seen on ccff_tail.
module ccff_chain_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  chain_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  ccff_head,
    output logic                  config_enable,
    input  logic                  ccff_tail,
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    output logic [LEN_WIDTH-1:0]  rb_ones,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  rem_d;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [CW-1:0]         bcnt_q;
    logic                  head_q;
    logic                  en_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  accept;
    logic                  xfer;

    // rem_q counts bits not yet shifted, including the one on ccff_head
    assign rem_d    = rem_q - LEN_WIDTH'(en_q);
    assign accept   = (state_q == IDLE) && start && !abort && (chain_len != '0);
    assign wr_ready = (state_q == LOAD) && !abort && (bcnt_q == '0) && (rem_d != '0);
    assign xfer     = wr_valid && wr_ready;

    assign ccff_head     = head_q;
    assign config_enable = en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            buf_q   <= '0;
            bcnt_q  <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    en_q <= 1'b0;
                    if (accept) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        rem_q   <= chain_len;
                        bcnt_q  <= '0;
                    end else if (start && !abort) begin
                        err_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                        rem_q   <= '0;
                        bcnt_q  <= '0;
                    end else begin
                        rem_q <= rem_d;
                        if (rem_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            en_q    <= 1'b0;
                        end else if (bcnt_q != '0) begin
                            head_q <= buf_q[DATA_WIDTH-1];
                            buf_q  <= buf_q << 1;
                            bcnt_q <= bcnt_q - CW'(1);
                            en_q   <= 1'b1;
                        end else if (xfer) begin
                            head_q <= wr_data[DATA_WIDTH-1];
                            buf_q  <= wr_data << 1;
                            bcnt_q <= CW'(DATA_WIDTH - 1);
                            en_q   <= 1'b1;
                        end else begin
                            en_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    bcnt_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [LEN_WIDTH-1:0] rb_q;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            rb_q <= '0;
        end else if (accept) begin
            rb_q <= '0;
        end else if (en_q && ccff_tail) begin
            rb_q <= rb_q + LEN_WIDTH'(1);
        end
    end

    assign rb_ones = rb_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized self-checking bench for ccff_chain_loader.
// The expected chain bitstream is the word list read MSB-first, cut at chain_len.
module tb_ccff_chain_loader;

    localparam int DW = 8;
    localparam int LW = 16;

    logic          prog_clk = 1'b0;
    logic          pReset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] chain_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          ccff_head;
    logic          config_enable;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          error;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [LW-1:0] rb_ones;
`endif

    int checks = 0;
    int errors = 0;

    ccff_chain_loader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .prog_clk(prog_clk),
        .pReset_n(pReset_n),
        .start(start),
        .abort(abort),
        .chain_len(chain_len),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .ccff_head(ccff_head),
        .config_enable(config_enable),
        .ccff_tail(ccff_tail),
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        .rb_ones(rb_ones),
`endif
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural configuration chain: shifts head in whenever enabled
    logic [255:0] chain = '0;
    int tap = 16;
    always @(posedge prog_clk) if (config_enable) chain <= {chain[254:0], ccff_head};
    assign ccff_tail = chain[tap-1];

    logic [7:0] words[$];
    logic       got[$];
    int en_cyc, done_cnt, hs_cnt, extra_rdy, inner_gap, busy_bad;
    bit timed_out;

    function automatic int bits_bad(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (i >= got.size() || got[i] !== words[i/8][7 - (i % 8)]) bad++;
        return bad;
    endfunction

    task automatic do_load(input int len, input int stall_pct, input int gap,
                           input int abort_at, input int inj_cyc);
        int wi, cyc, gap_left, low_run, nw;
        bit seen_en;
        got.delete();
        en_cyc = 0; done_cnt = 0; hs_cnt = 0; extra_rdy = 0;
        inner_gap = 0; busy_bad = 0; timed_out = 0;
        nw = (len + 7) / 8;
        tap = len;
        @(negedge prog_clk);
        start = 1'b1; chain_len = LW'(len);
        @(negedge prog_clk);
        start = 1'b0;
        wi = 0; cyc = 0; gap_left = -1; low_run = 0; seen_en = 0;
        forever begin
            if (!busy) busy_bad++;
            if (config_enable) begin
                got.push_back(ccff_head);
                en_cyc++;
                if (seen_en) inner_gap += low_run;
                low_run = 0;
                seen_en = 1;
            end else if (seen_en) begin
                low_run++;
            end
            if (done) begin done_cnt++; break; end
            if (wi >= nw && wr_ready) extra_rdy++;
            abort = (abort_at > 0 && config_enable && got.size() == abort_at);
            start = (cyc == inj_cyc);
            if (start) chain_len = LW'($urandom_range(1, 200));
            if (wi < nw) begin
                if (gap > 0 && wi == 1 && gap_left < 0 && wr_ready) gap_left = gap;
                if (gap_left > 0) begin
                    wr_valid = 1'b0;
                    gap_left--;
                end else begin
                    wr_valid = ($urandom_range(99) >= stall_pct);
                end
                wr_data = words[wi];
            end else begin
                wr_valid = 1'b0;
            end
            if (wr_valid && wr_ready) begin hs_cnt++; wi++; end
            @(negedge prog_clk);
            cyc++;
            start = 1'b0;
            if (abort) begin abort = 1'b0; break; end
            if (cyc > 2000) begin timed_out = 1; break; end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge prog_clk);
        checks++;
        if ({wr_ready, ccff_head, config_enable, busy, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000000",
                     {wr_ready, ccff_head, config_enable, busy, done, error});
        end
        pReset_n = 1'b1;
        @(negedge prog_clk);
        checks++;
        if ({busy, wr_ready, config_enable} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release_idle got %b exp 000", {busy, wr_ready, config_enable});
        end
    endtask

    task automatic test_basic();
        words = {8'hA5, 8'h3C};
        do_load(16, 0, 0, 0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
        checks++; if (bits_bad(16) != 0 || got.size() != 16) begin errors++; $display("FAIL basic_bits got %0d bad of %0d exp 0 bad of 16", bits_bad(16), got.size()); end
        checks++; if (en_cyc != 16) begin errors++; $display("FAIL basic_en_cycles got %0d exp 16", en_cyc); end
        checks++; if (inner_gap != 0) begin errors++; $display("FAIL basic_bubbles got %0d exp 0", inner_gap); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy got %0d low cycles exp 0", busy_bad); end
        @(negedge prog_clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_partial();
        words = {8'hFF, 8'hC0};
        do_load(10, 0, 0, 0, -1);
        checks++; if (bits_bad(10) != 0 || got.size() != 10) begin errors++; $display("FAIL partial_bits got %0d bad of %0d exp 0 bad of 10", bits_bad(10), got.size()); end
        checks++; if (en_cyc != 10) begin errors++; $display("FAIL partial_en_cycles got %0d exp 10", en_cyc); end
        checks++; if (hs_cnt != 2) begin errors++; $display("FAIL partial_handshakes got %0d exp 2", hs_cnt); end
        checks++; if (extra_rdy != 0) begin errors++; $display("FAIL partial_extra_ready got %0d exp 0", extra_rdy); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL partial_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_gap();
        words = {8'($urandom), 8'($urandom)};
        do_load(16, 0, 3, 0, -1);
        checks++; if (inner_gap != 3) begin errors++; $display("FAIL gap_low_cycles got %0d exp 3", inner_gap); end
        checks++; if (en_cyc != 16) begin errors++; $display("FAIL gap_en_cycles got %0d exp 16", en_cyc); end
        checks++; if (bits_bad(16) != 0) begin errors++; $display("FAIL gap_bits got %0d bad exp 0", bits_bad(16)); end
    endtask

    task automatic test_zero_len();
        @(negedge prog_clk);
        start = 1'b1; chain_len = '0;
        @(negedge prog_clk);
        start = 1'b0;
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_len_err got error=%b busy=%b exp 1 0", error, busy); end
        @(negedge prog_clk);
        checks++; if (error !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL zero_len_pulse got error=%b busy=%b ready=%b exp 0 0 0", error, busy, wr_ready); end
    endtask

    task automatic test_abort();
        int late_done = 0;
        words = {8'($urandom), 8'($urandom)};
        do_load(16, 0, 0, 5, -1);
        checks++; if (got.size() != 5 || bits_bad(5) != 0) begin errors++; $display("FAIL abort_bits got %0d bits %0d bad exp 5 bits 0 bad", got.size(), bits_bad(5)); end
        checks++; if (config_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_stop got en=%b busy=%b exp 0 0", config_enable, busy); end
        repeat (3) begin
            @(negedge prog_clk);
            if (done !== 1'b0 || config_enable !== 1'b0) late_done++;
        end
        checks++; if (done_cnt != 0 || late_done != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt + late_done); end
        words = {8'($urandom), 8'($urandom)};
        do_load(16, 0, 0, 0, -1);
        checks++; if (en_cyc != 16 || done_cnt != 1 || bits_bad(16) != 0) begin errors++; $display("FAIL abort_restart got en=%0d done=%0d bad=%0d exp 16 1 0", en_cyc, done_cnt, bits_bad(16)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int len, nw, inj;
            len = $urandom_range(1, 40);
            nw = (len + 7) / 8;
            words.delete();
            for (int w = 0; w < nw; w++) words.push_back(8'($urandom));
            inj = ($urandom_range(3) == 0) ? $urandom_range(1, 20) : -1;
            do_load(len, $urandom_range(0, 60), 0, 0, inj);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout got 1 exp 0", it); end
            checks++; if (bits_bad(len) != 0) begin errors++; $display("FAIL rand%0d_bits got %0d bad exp 0 (len %0d)", it, bits_bad(len), len); end
            checks++; if (en_cyc != len) begin errors++; $display("FAIL rand%0d_en_cycles got %0d exp %0d", it, en_cyc, len); end
            checks++; if (done_cnt != 1 || busy_bad != 0) begin errors++; $display("FAIL rand%0d_done_busy got done=%0d busylow=%0d exp 1 0", it, done_cnt, busy_bad); end
            checks++; if (hs_cnt != nw || extra_rdy != 0) begin errors++; $display("FAIL rand%0d_words got hs=%0d extra=%0d exp %0d 0", it, hs_cnt, extra_rdy, nw); end
        end
    endtask

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    task automatic test_readback();
        int prior;
        tap = 16;
        prior = $countones(chain[15:0]);
        words = {8'h00, 8'hF3};
        do_load(16, 0, 0, 0, -1);
        checks++; if (rb_ones !== LW'(prior)) begin errors++; $display("FAIL rb_first got %0d exp %0d", rb_ones, prior); end
        words = {8'($urandom), 8'($urandom)};
        do_load(16, 20, 0, 0, -1);
        checks++; if (rb_ones !== LW'(6)) begin errors++; $display("FAIL rb_popcount got %0d exp 6", rb_ones); end
        repeat (3) @(negedge prog_clk);
        checks++; if (rb_ones !== LW'(6)) begin errors++; $display("FAIL rb_hold got %0d exp 6", rb_ones); end
    endtask
`endif

    task automatic test_reset_mid_load();
        int bad = 0;
        words = {8'h5A, 8'h99};
        tap = 16;
        @(negedge prog_clk);
        start = 1'b1; chain_len = LW'(16);
        @(negedge prog_clk);
        start = 1'b0; wr_valid = 1'b1; wr_data = words[0];
        repeat (4) @(negedge prog_clk);
        #2 pReset_n = 1'b0;
        #1;
        checks++;
        if ({wr_ready, ccff_head, config_enable, busy, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async got %b exp 000000",
                     {wr_ready, ccff_head, config_enable, busy, done, error});
        end
        @(negedge prog_clk);
        #2 pReset_n = 1'b1;
        repeat (6) begin
            @(negedge prog_clk);
            if (config_enable || busy || wr_ready) bad++;
        end
        wr_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_abandon got %0d active cycles exp 0", bad); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_gap();
        test_zero_len();
        test_abort();
        test_random();
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        test_readback();
`endif
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per input word.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of chain length and bit counters.
REQ-003 SHALL have port prog_clk  input  1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port pReset_n  input  1: reset, asynchronous assert and active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1: terminates any load in progress.
REQ-007 SHALL have port chain_len  input  LEN_WIDTH: number of chain bits to shift; latched on an accepted start.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH: bitstream word, shifted out MSB first.
REQ-009 SHALL have ports wr_valid input 1 and wr_ready output 1: word handshake; a transfer occurs on an edge where both are high.
REQ-010 SHALL have port ccff_head  output  1: serial data to the head of the configuration chain.
REQ-011 SHALL have port config_enable  output  1: chain shift enable; the chain shifts one bit on each prog_clk edge where it is high.
REQ-012 SHALL have port ccff_tail  input  1: serial data returned from the tail of the chain.
REQ-013 SHALL have ports busy output 1, done output 1 and error output 1: status outputs.

Function
REQ-014 SHALL implement states IDLE, LOAD and DONE.
REQ-015 SHALL, in IDLE, move to LOAD on start with chain_len != 0, and latch chain_len.
REQ-016 SHALL, in IDLE, on start with chain_len == 0, pulse error for 1 cycle and stay in IDLE.
REQ-017 SHALL assert busy in LOAD and DONE, and ignore start while busy.
REQ-018 SHALL drive ccff_head and config_enable from registers only.
REQ-019 SHALL, for a word accepted at edge k, present its MSB on ccff_head with config_enable high during the cycle after edge k.
REQ-020 SHALL assert wr_ready in LOAD only when the word buffer is empty or is presenting its last bit, and never when the remaining bit count is zero.
REQ-021 SHALL keep config_enable continuously high for exactly chain_len cycles when wr_valid is held high; no bubbles between words.
REQ-022 SHALL, when the next word is not yet available, drop config_enable low and hold ccff_head; the remaining bit count is unchanged.
REQ-023 SHALL discard the unused low-order bits of the final word when chain_len is not a multiple of DATA_WIDTH; no further word is requested.
REQ-024 SHALL move to DONE on the edge the last bit shifts; in DONE, pulse done for 1 cycle, then return to IDLE.
REQ-025 SHALL, when abort is high, force config_enable low and return to IDLE on the next edge with no done pulse; abort takes priority over a simultaneous handshake or last shift.
REQ-026 SHALL keep the total number of config_enable-high cycles per load at most chain_len.

Reset
REQ-027 SHALL, while pReset_n is low, force state IDLE, ccff_head 0, config_enable 0, wr_ready 0, busy 0, done 0, error 0 and all counters 0, asynchronously.
REQ-028 SHALL, on reset during LOAD, abandon the load; after release, a new start is required.

Configuration
REQ-029 SHALL, when CCFF_CHAIN_LOADER_READBACK_EN is defined, add output rb_ones (LEN_WIDTH).
REQ-030 SHALL, with that macro, clear rb_ones on an accepted start and increment it on every edge where config_enable is high and ccff_tail is 1.
REQ-031 SHALL, with that macro, hold rb_ones stable from DONE until the next start; it is the popcount of the prior chain contents.
REQ-032 SHALL, without that macro, omit rb_ones and ignore ccff_tail.

Verification
REQ-033 SHALL cover: DATA_WIDTH=8, chain_len=16, words 0xA5 then 0x3C, wr_valid held high -> ccff_head 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with config_enable high for 16 contiguous cycles, then done pulses once.
REQ-034 SHALL cover: chain_len=10, words 0xFF then 0xC0 -> 10 enable cycles, last two bits 1,1, no third wr_ready.
REQ-035 SHALL cover: chain_len=16, wr_valid low for 3 cycles between words -> config_enable low for exactly 3 cycles, total 16 shifted bits correct.
REQ-036 SHALL cover: start with chain_len=0 -> error pulses 1 cycle, busy stays 0.
REQ-037 SHALL cover: abort after 5 shifted bits of a 16-bit load -> config_enable 0 next cycle, IDLE, no done; a fresh start then works.
REQ-038 SHALL cover: with READBACK_EN, a preloaded chain of 16 bits holding 0x00F3 reloaded -> rb_ones == 6 at done.
